// File: rtl/ov_yuv_capture.sv
// Byte-serial YUV422 capture: frames the sensor stream on vsync/href and emits
// one luma byte per pixel strobe, with sticky line/frame geometry error flags.
module ov_yuv_capture #(
  parameter int WIDTH   = 640,
  parameter int HEIGHT  = 480,
  parameter bit Y_FIRST = 1'b1
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        vsync,
  input  logic        href,
  input  logic [7:0]  cam_data,
  input  logic        capture_en,
  output logic        pix_valid,
  output logic [7:0]  pix_y,
  output logic        frame_active,
  output logic        frame_done,
  output logic [11:0] line_count,
  output logic        line_err,
  output logic        frame_err
);

  localparam logic [11:0] LINE_BYTES = 12'(2 * WIDTH);
  localparam logic [11:0] LINES      = 12'(HEIGHT);

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_SYNC, S_ACTIVE} state_t;

  state_t      state_q;
  logic        vsync_q, href_q;
  logic [11:0] byte_idx_q, byte_idx_d;
  logic [11:0] line_count_q;
  logic        extra_line_q;
  logic        pix_valid_q, frame_done_q, line_err_q, frame_err_q;
  logic [7:0]  pix_y_q;

  logic vs_rise, vs_fall, href_fall, is_luma, lines_full, pix_hit;

  always_comb begin
    vs_rise    = vsync & ~vsync_q;
    vs_fall    = ~vsync & vsync_q;
    href_fall  = ~href & href_q;
    is_luma    = (byte_idx_q[0] == ~Y_FIRST);
    lines_full = (line_count_q >= LINES);
    byte_idx_d = (byte_idx_q == 12'hFFF) ? byte_idx_q : byte_idx_q + 12'd1;
    // A vsync edge ends the frame immediately, so that cycle's byte is dropped.
    pix_hit    = (state_q == S_ACTIVE) & href & ~vs_rise & is_luma &
                 (byte_idx_q < LINE_BYTES) & ~lines_full;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q      <= S_IDLE;
      vsync_q      <= 1'b0;
      href_q       <= 1'b0;
      byte_idx_q   <= '0;
      line_count_q <= '0;
      extra_line_q <= 1'b0;
      pix_valid_q  <= 1'b0;
      pix_y_q      <= '0;
      frame_done_q <= 1'b0;
      line_err_q   <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      vsync_q      <= vsync;
      href_q       <= href;
      frame_done_q <= 1'b0;
      pix_valid_q  <= pix_hit;
      if (pix_hit) pix_y_q <= cam_data;

      case (state_q)
        S_IDLE: if (capture_en) state_q <= S_ARM;
        S_ARM:  if (vs_rise) state_q <= S_SYNC;
        S_SYNC: begin
          line_count_q <= '0;
          byte_idx_q   <= '0;
          extra_line_q <= 1'b0;
          if (vs_fall) state_q <= S_ACTIVE;
        end
        S_ACTIVE: begin
          if (vs_rise) begin
            frame_done_q <= 1'b1;
            if ((line_count_q != LINES) || extra_line_q) frame_err_q <= 1'b1;
            if (href) line_err_q <= 1'b1;
            byte_idx_q <= '0;
            state_q    <= capture_en ? S_SYNC : S_IDLE;
          end else if (href) begin
            byte_idx_q <= byte_idx_d;
          end else if (href_fall) begin
            byte_idx_q <= '0;
            if (!lines_full) begin
              line_count_q <= line_count_q + 12'd1;
              if (byte_idx_q != LINE_BYTES) line_err_q <= 1'b1;
            end else begin
              // Surplus lines leave line_count at HEIGHT; remember them for frame_err.
              extra_line_q <= 1'b1;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign pix_valid    = pix_valid_q;
  assign pix_y        = pix_y_q;
  assign frame_active = (state_q == S_ACTIVE);
  assign frame_done   = frame_done_q;
  assign line_count   = line_count_q;
  assign line_err     = line_err_q;
  assign frame_err    = frame_err_q;

endmodule

// File: tb/tb_ov_yuv_capture.sv
// Directed bench for ov_yuv_capture: a YUYV and a UYVY instance share one
// sensor bus (WIDTH=4, HEIGHT=2) and are checked against hand-computed vectors.
module tb_ov_yuv_capture;

  logic        clk = 1'b0;
  logic        HRESETn = 1'b1;
  logic        vsync = 1'b0, href = 1'b0, capture_en = 1'b0;
  logic [7:0]  cam_data = '0;

  logic        pv_a, fa_a, fd_a, le_a, fe_a;
  logic [7:0]  py_a;
  logic [11:0] lc_a;
  logic        pv_b, fa_b, fd_b, le_b, fe_b;
  logic [7:0]  py_b;
  logic [11:0] lc_b;

  int errors = 0;
  int checks = 0;

  logic [7:0] qa[$];
  logic [7:0] qb[$];
  int   done_a = 0;
  int   b2b = 0;
  logic prev_a = 1'b0;
  logic fe_at_done = 1'b0;

  always #5 clk = ~clk;

  ov_yuv_capture #(.WIDTH(4), .HEIGHT(2), .Y_FIRST(1'b1)) u_dut (
    .HCLK(clk), .HRESETn(HRESETn), .vsync(vsync), .href(href), .cam_data(cam_data),
    .capture_en(capture_en), .pix_valid(pv_a), .pix_y(py_a), .frame_active(fa_a),
    .frame_done(fd_a), .line_count(lc_a), .line_err(le_a), .frame_err(fe_a));

  ov_yuv_capture #(.WIDTH(4), .HEIGHT(2), .Y_FIRST(1'b0)) u_dut_uy (
    .HCLK(clk), .HRESETn(HRESETn), .vsync(vsync), .href(href), .cam_data(cam_data),
    .capture_en(capture_en), .pix_valid(pv_b), .pix_y(py_b), .frame_active(fa_b),
    .frame_done(fd_b), .line_count(lc_b), .line_err(le_b), .frame_err(fe_b));

  always @(negedge clk) begin
    if (pv_a) qa.push_back(py_a);
    if (pv_b) qb.push_back(py_b);
    if (pv_a && prev_a) b2b++;
    prev_a = pv_a;
    if (fd_a) begin
      done_a++;
      fe_at_done = fe_a;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic apply_reset();
    HRESETn = 1'b0; vsync = 1'b0; href = 1'b0; cam_data = '0; capture_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    HRESETn = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    href = 1'b1;
    cam_data = b;
    tick(1);
  endtask

  task automatic end_line();
    href = 1'b0;
    cam_data = '0;
    tick(2);
  endtask

  task automatic send_line(input logic [7:0] y0, input logic [7:0] c0, input int nbytes);
    for (int i = 0; i < nbytes; i++)
      send_byte((i % 2 == 0) ? y0 + 8'(i / 2) : c0 + 8'(i / 2));
    end_line();
  endtask

  task automatic vs_pulse();
    href = 1'b0;
    vsync = 1'b1;
    tick(2);
    vsync = 1'b0;
    tick(2);
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (pv_a !== 1'b0)  begin errors++; $display("FAIL rst_pix_valid got %b want 0", pv_a); end
    checks++; if (py_a !== 8'h00) begin errors++; $display("FAIL rst_pix_y got %h want 00", py_a); end
    checks++; if (fa_a !== 1'b0)  begin errors++; $display("FAIL rst_frame_active got %b want 0", fa_a); end
    checks++; if (fd_a !== 1'b0)  begin errors++; $display("FAIL rst_frame_done got %b want 0", fd_a); end
    checks++; if (lc_a !== 12'd0) begin errors++; $display("FAIL rst_line_count got %0d want 0", lc_a); end
    checks++; if (le_a !== 1'b0)  begin errors++; $display("FAIL rst_line_err got %b want 0", le_a); end
    checks++; if (fe_a !== 1'b0)  begin errors++; $display("FAIL rst_frame_err got %b want 0", fe_a); end
  endtask

  task automatic test_nominal();
    logic [7:0] exp_a [8] = '{8'd10, 8'd11, 8'd12, 8'd13, 8'd20, 8'd21, 8'd22, 8'd23};
    logic [7:0] exp_b [8] = '{8'd80, 8'd81, 8'd82, 8'd83, 8'd90, 8'd91, 8'd92, 8'd93};
    int sa, sb, db;
    logic ev;
    apply_reset();
    capture_en = 1'b1;
    tick(2);
    vs_pulse();
    checks++; if (fa_a !== 1'b1) begin errors++; $display("FAIL nom_frame_active got %b want 1", fa_a); end
    sa = qa.size(); sb = qb.size(); db = done_a;
    for (int i = 0; i < 8; i++) begin
      send_byte((i % 2 == 0) ? 8'd10 + 8'(i / 2) : 8'd80 + 8'(i / 2));
      ev = (i % 2 == 0);
      checks++; if (pv_a !== ev) begin errors++; $display("FAIL nom_valid_yuyv byte %0d got %b want %b", i, pv_a, ev); end
      checks++; if (py_a !== 8'd10 + 8'(i / 2)) begin errors++; $display("FAIL nom_pix_y byte %0d got %0d want %0d", i, py_a, 10 + i / 2); end
      checks++; if (pv_b !== ~ev) begin errors++; $display("FAIL nom_valid_uyvy byte %0d got %b want %b", i, pv_b, ~ev); end
    end
    end_line();
    send_line(8'd20, 8'd90, 8);
    checks++; if (lc_a !== 12'd2) begin errors++; $display("FAIL nom_line_count got %0d want 2", lc_a); end
    vs_pulse();
    checks++; if (done_a - db !== 1) begin errors++; $display("FAIL nom_frame_done got %0d want 1", done_a - db); end
    checks++; if (le_a !== 1'b0 || fe_a !== 1'b0) begin errors++; $display("FAIL nom_errors got le=%b fe=%b want 0 0", le_a, fe_a); end
    checks++; if (qa.size() - sa !== 8) begin errors++; $display("FAIL nom_count_yuyv got %0d want 8", qa.size() - sa); end
    checks++; if (qb.size() - sb !== 8) begin errors++; $display("FAIL nom_count_uyvy got %0d want 8", qb.size() - sb); end
    for (int k = 0; k < 8; k++) begin
      if (sa + k < qa.size()) begin
        checks++; if (qa[sa + k] !== exp_a[k]) begin errors++; $display("FAIL nom_seq_yuyv %0d got %0d want %0d", k, qa[sa + k], exp_a[k]); end
      end
      if (sb + k < qb.size()) begin
        checks++; if (qb[sb + k] !== exp_b[k]) begin errors++; $display("FAIL nom_seq_uyvy %0d got %0d want %0d", k, qb[sb + k], exp_b[k]); end
      end
    end
  endtask

  task automatic test_short_line();
    int sa, db;
    apply_reset();
    capture_en = 1'b1;
    tick(2);
    vs_pulse();
    sa = qa.size(); db = done_a;
    send_line(8'd30, 8'd0, 6);
    checks++; if (qa.size() - sa !== 3) begin errors++; $display("FAIL short_count got %0d want 3", qa.size() - sa); end
    checks++; if (le_a !== 1'b1) begin errors++; $display("FAIL short_line_err got %b want 1", le_a); end
    checks++; if (lc_a !== 12'd1) begin errors++; $display("FAIL short_line_count got %0d want 1", lc_a); end
    send_line(8'd60, 8'd0, 8);
    vs_pulse();
    checks++; if (done_a - db !== 1 || fe_at_done !== 1'b0) begin errors++; $display("FAIL short_frame got done=%0d fe=%b want 1 0", done_a - db, fe_at_done); end
  endtask

  task automatic test_long_line();
    int sa, db;
    apply_reset();
    capture_en = 1'b1;
    tick(2);
    vs_pulse();
    sa = qa.size(); db = done_a;
    send_line(8'd40, 8'd0, 10);
    checks++; if (qa.size() - sa !== 4) begin errors++; $display("FAIL long_count got %0d want 4", qa.size() - sa); end
    checks++; if (le_a !== 1'b1) begin errors++; $display("FAIL long_line_err got %b want 1", le_a); end
    send_line(8'd50, 8'd0, 8);
    send_line(8'd70, 8'd0, 8);
    checks++; if (qa.size() - sa !== 8) begin errors++; $display("FAIL extra_line_count got %0d want 8", qa.size() - sa); end
    checks++; if (lc_a !== 12'd2) begin errors++; $display("FAIL extra_line_sat got %0d want 2", lc_a); end
    vs_pulse();
    checks++; if (done_a - db !== 1 || fe_at_done !== 1'b1) begin errors++; $display("FAIL extra_frame_err got done=%0d fe=%b want 1 1", done_a - db, fe_at_done); end
    if (sa + 4 < qa.size()) begin
      checks++; if (qa[sa + 3] !== 8'd43 || qa[sa + 4] !== 8'd50) begin errors++; $display("FAIL long_values got %0d %0d want 43 50", qa[sa + 3], qa[sa + 4]); end
    end
  endtask

  task automatic test_arm_mid_frame();
    int sa;
    apply_reset();
    tick(2);
    sa = qa.size();
    for (int i = 0; i < 8; i++) begin
      if (i == 3) capture_en = 1'b1;
      send_byte(8'd100 + 8'(i));
    end
    end_line();
    send_line(8'd110, 8'd0, 8);
    checks++; if (qa.size() - sa !== 0) begin errors++; $display("FAIL arm_no_pixels got %0d want 0", qa.size() - sa); end
    checks++; if (fa_a !== 1'b0) begin errors++; $display("FAIL arm_active got %b want 0", fa_a); end
    vs_pulse();
    send_line(8'd72, 8'd0, 8);
    checks++; if (qa.size() - sa !== 4) begin errors++; $display("FAIL arm_after_vsync got %0d want 4", qa.size() - sa); end
    if (sa < qa.size()) begin
      checks++; if (qa[sa] !== 8'd72) begin errors++; $display("FAIL arm_first_pix got %0d want 72", qa[sa]); end
    end
  endtask

  task automatic test_reset_mid_line();
    int sa, db;
    apply_reset();
    capture_en = 1'b1;
    tick(2);
    vs_pulse();
    send_line(8'd30, 8'd0, 6);
    checks++; if (le_a !== 1'b1) begin errors++; $display("FAIL rmid_pre_line_err got %b want 1", le_a); end
    for (int i = 0; i < 3; i++) send_byte(8'd33);
    checks++; if (pv_a !== 1'b1) begin errors++; $display("FAIL rmid_pre_valid got %b want 1", pv_a); end
    HRESETn = 1'b0;
    #1;
    checks++; if (pv_a !== 1'b0 || py_a !== 8'h00) begin errors++; $display("FAIL rmid_pix got v=%b y=%h want 0 00", pv_a, py_a); end
    checks++; if (le_a !== 1'b0 || fe_a !== 1'b0) begin errors++; $display("FAIL rmid_flags got le=%b fe=%b want 0 0", le_a, fe_a); end
    checks++; if (fa_a !== 1'b0 || lc_a !== 12'd0) begin errors++; $display("FAIL rmid_state got fa=%b lc=%0d want 0 0", fa_a, lc_a); end
    @(posedge clk);
    #1;
    HRESETn = 1'b1;
    href = 1'b0;
    cam_data = '0;
    tick(2);
    vs_pulse();
    sa = qa.size(); db = done_a;
    send_line(8'd1, 8'd200, 8);
    send_line(8'd5, 8'd210, 8);
    vs_pulse();
    checks++; if (qa.size() - sa !== 8) begin errors++; $display("FAIL rmid_count got %0d want 8", qa.size() - sa); end
    checks++; if (done_a - db !== 1 || fe_at_done !== 1'b0 || le_a !== 1'b0) begin
      errors++; $display("FAIL rmid_frame got done=%0d fe=%b le=%b want 1 0 0", done_a - db, fe_at_done, le_a);
    end
    if (sa + 7 < qa.size()) begin
      checks++; if (qa[sa] !== 8'd1 || qa[sa + 7] !== 8'd8) begin errors++; $display("FAIL rmid_values got %0d %0d want 1 8", qa[sa], qa[sa + 7]); end
    end
  endtask

  task automatic test_back_to_back();
    checks++; if (b2b !== 0) begin errors++; $display("FAIL back_to_back_strobes got %0d want 0", b2b); end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_short_line();
    test_long_line();
    test_arm_mid_frame();
    test_reset_mid_line();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
